// File: rtl/data_delta_decode.sv
// Delta decoder: rebuilds DW-bit samples from key (absolute) words and signed
// differences against a running reference, behind one registered output stage.
//
// state | meaning
// IDLE  | no reference sample yet; difference words are dropped
// RUN   | acc holds a valid reference; differences update it
module data_delta_decode #(
  parameter int DW  = 8,
  parameter int SAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_key,
  input  logic [DW:0]   in_diff,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_key,
  output logic          out_sat,
  output logic          err_nokey,
  input  logic          clr_err,
  output logic [15:0]   sample_cnt
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t               state, state_nxt;
  logic [DW-1:0]        acc;
  logic                 accept, load, drop;
  logic signed [DW+1:0] sum;
  logic [DW-1:0]        result;
  logic                 result_sat;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  // acc is zero-extended, the difference sign-extended; DW+2 bits cannot overflow
  assign sum      = $signed({2'b00, acc}) + $signed({in_diff[DW], in_diff});
  assign out_data = acc;

  always_comb begin
    state_nxt  = state;
    load       = 1'b0;
    drop       = 1'b0;
    result     = acc;
    result_sat = 1'b0;
    if (accept) begin
      if (in_key) begin
        load      = 1'b1;
        result    = in_diff[DW-1:0];
        state_nxt = RUN;
      end else if (state == IDLE) begin
        drop = 1'b1;
      end else begin
        load = 1'b1;
        if (sum[DW+1]) begin
          result_sat = 1'b1;
          result     = (SAT != 0) ? '0 : sum[DW-1:0];
        end else if (sum[DW]) begin
          result_sat = 1'b1;
          result     = (SAT != 0) ? '1 : sum[DW-1:0];
        end else begin
          result = sum[DW-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      out_valid  <= 1'b0;
      out_key    <= 1'b0;
      out_sat    <= 1'b0;
      err_nokey  <= 1'b0;
      sample_cnt <= '0;
    end else begin
      if (load) begin
        acc        <= result;
        out_key    <= in_key;
        out_sat    <= result_sat;
        out_valid  <= 1'b1;
        sample_cnt <= sample_cnt + 16'd1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // a drop in the same cycle as a clear must leave the flag set
      if (drop)         err_nokey <= 1'b1;
      else if (clr_err) err_nokey <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_delta_decode.sv
// Scoreboard bench for data_delta_decode: one clamping and one wrapping instance
// share stimulus; an arithmetic reference model predicts every emitted sample.
module tb_data_delta_decode;

  typedef struct packed {
    logic [7:0]  d;
    logic        k;
    logic        s;
    logic [15:0] c;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_key, out_ready, clr_err;
  logic [8:0] in_diff;

  logic        ir [2];
  logic        ov [2];
  logic [7:0]  od [2];
  logic        ok [2];
  logic        os [2];
  logic        en [2];
  logic [15:0] sc [2];

  int checks = 0;
  int errors = 0;
  bit rand_mode = 1'b0;

  exp_t  q1[$];
  exp_t  q0[$];
  bit    m_valid, m_run, m_err, m_acc_now;
  logic [15:0] m_cnt;
  int    m_a1, m_a0;

  always #5 clk = ~clk;

  data_delta_decode #(.DW(8), .SAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
    .in_key(in_key), .in_diff(in_diff), .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od[1]), .out_key(ok[1]), .out_sat(os[1]), .err_nokey(en[1]),
    .clr_err(clr_err), .sample_cnt(sc[1]));

  data_delta_decode #(.DW(8), .SAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
    .in_key(in_key), .in_diff(in_diff), .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od[0]), .out_key(ok[0]), .out_sat(os[0]), .err_nokey(en[0]),
    .clr_err(clr_err), .sample_cnt(sc[0]));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: actual %0d required %0d", nm, $time, act, exp);
    end
  endtask

  // Reference: plain integer sum, then clamp or wrap into 0..255.
  function automatic void calc(input int acc, input int diff, input bit sat,
                               output int res, output bit oor);
    int s;
    s   = acc + diff;
    oor = (s < 0) || (s > 255);
    if (!oor)       res = s;
    else if (!sat)  res = s & 255;
    else            res = (s < 0) ? 0 : 255;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_run = 0; m_err = 0; m_cnt = '0; m_a1 = 0; m_a0 = 0;
      m_acc_now = 0;
      q1.delete(); q0.delete();
    end else begin
      bit ld, drop, s1, s0;
      int r1, r0, diff;
      ld = 0; drop = 0; s1 = 0; s0 = 0; r1 = 0; r0 = 0;
      diff = int'($signed(in_diff));
      m_acc_now = in_valid && (!m_valid || out_ready);
      if (m_acc_now) begin
        if (in_key) begin
          r1 = int'(in_diff[7:0]); r0 = r1; m_run = 1; ld = 1;
        end else if (!m_run) begin
          drop = 1;
        end else begin
          calc(m_a1, diff, 1'b1, r1, s1);
          calc(m_a0, diff, 1'b0, r0, s0);
          ld = 1;
        end
      end
      if (ld) begin
        m_cnt = m_cnt + 16'd1;
        m_a1 = r1; m_a0 = r0;
        q1.push_back('{d: 8'(r1), k: in_key, s: s1, c: m_cnt});
        q0.push_back('{d: 8'(r0), k: in_key, s: s0, c: m_cnt});
        m_valid = 1;
      end else if (out_ready) begin
        m_valid = 0;
      end
      if (drop)         m_err = 1;
      else if (clr_err) m_err = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        chk("in_ready", int'(ir[i]), int'(!m_valid || out_ready));
        chk("out_valid", int'(ov[i]), int'(m_valid));
        chk("err_nokey", int'(en[i]), int'(m_err));
        chk("sample_cnt", int'(sc[i]), int'(m_cnt));
      end
      if (ov[1]) begin
        if (q1.size() == 0) chk("sb1_empty", 1, 0);
        else begin
          chk("sb1_data", int'(od[1]), int'(q1[0].d));
          chk("sb1_key", int'(ok[1]), int'(q1[0].k));
          chk("sb1_sat", int'(os[1]), int'(q1[0].s));
          if (out_ready) void'(q1.pop_front());
        end
      end
      if (ov[0]) begin
        if (q0.size() == 0) chk("sb0_empty", 1, 0);
        else begin
          chk("sb0_data", int'(od[0]), int'(q0[0].d));
          chk("sb0_key", int'(ok[0]), int'(q0[0].k));
          chk("sb0_sat", int'(os[0]), int'(q0[0].s));
          if (out_ready) void'(q0.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
    if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) tick();
  endtask

  task automatic send(input bit k, input int d);
    bit got;
    got = 0;
    in_valid = 1; in_key = k; in_diff = d[8:0];
    for (int n = 0; n < 200 && !got; n++) begin
      @(posedge clk); #1;
      got = m_acc_now;
      #1;
      if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
    end
    if (!got) chk("send_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic do_reset();
    in_valid = 0;
    rst_n = 0;
    @(posedge clk); #2;
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0; in_valid = 0; in_key = 0; in_diff = '0; clr_err = 0; out_ready = 1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_out_valid", int'(ov[i]), 0);
      chk("rst_out_data", int'(od[i]), 0);
      chk("rst_out_key", int'(ok[i]), 0);
      chk("rst_out_sat", int'(os[i]), 0);
      chk("rst_err", int'(en[i]), 0);
      chk("rst_cnt", int'(sc[i]), 0);
    end
    repeat (2) @(posedge clk);
    #2; rst_n = 1;

    send(1, 100);
    chk("t1_key_out", int'(od[1]), 100);
    chk("t1_key_flag", int'(ok[1]), 1);
    send(0, -40);
    send(0, 60);
    chk("t1_last", int'(od[1]), 120);
    chk("t1_cnt", int'(sc[1]), 3);
    idle(1);

    send(1, 10);
    send(0, -50);
    chk("t2_clamp_lo", int'(od[1]), 0);
    chk("t2_wrap_lo", int'(od[0]), 216);
    chk("t2_sat_lo", int'(os[1] & os[0]), 1);
    send(1, 250);
    send(0, 20);
    chk("t2_clamp_hi", int'(od[1]), 255);
    chk("t2_wrap_hi", int'(od[0]), 14);
    chk("t2_sat_hi", int'(os[1] & os[0]), 1);
    send(1, 9'h1FF);
    chk("t2_key_msb_ignored", int'(od[1]), 255);
    idle(1);

    do_reset();
    send(0, 5);
    idle(2);
    chk("t3_dropped", int'(ov[1]), 0);
    chk("t3_err", int'(en[1]), 1);
    send(1, 7);
    chk("t3_key7", int'(od[1]), 7);
    idle(1);
    clr_err = 1; tick(); clr_err = 0;
    chk("t3_clr", int'(en[1]), 0);
    do_reset();
    clr_err = 1;
    send(0, 9);
    clr_err = 0;
    chk("t3_set_wins", int'(en[0]), 1);
    idle(1);

    out_ready = 1;
    send(1, 30);
    out_ready = 0;
    in_valid = 1; in_key = 0; in_diff = 9'd1;
    repeat (3) tick();
    chk("t4_hold_data", int'(od[1]), 30);
    chk("t4_hold_ready", int'(ir[1]), 0);
    out_ready = 1;
    send(0, 1);
    send(0, 1);
    chk("t4_last", int'(od[1]), 32);
    idle(2);

    out_ready = 0;
    send(1, 77);
    idle(2);
    #1 rst_n = 0;
    #1;
    chk("t5_rst_valid", int'(ov[1]), 0);
    chk("t5_rst_data", int'(od[1]), 0);
    @(posedge clk); #2;
    rst_n = 1; out_ready = 1;
    send(0, 3);
    idle(1);
    chk("t5_err", int'(en[1]), 1);
    chk("t5_novalid", int'(ov[1]), 0);

    rand_mode = 1;
    send(1, int'($urandom_range(0, 255)));
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) send(1, int'($urandom_range(0, 511)));
      else                           send(0, int'($urandom_range(0, 511)) - 256);
      if ($urandom_range(0, 5) == 0) idle(int'($urandom_range(1, 3)));
      if ($urandom_range(0, 40) == 0) begin
        clr_err = 1; tick(); clr_err = 0;
      end
      if ($urandom_range(0, 300) == 0) begin
        do_reset();
        send(0, int'($urandom_range(0, 511)) - 256);
        send(1, int'($urandom_range(0, 255)));
      end
    end
    rand_mode = 0;
    out_ready = 1;
    idle(3);

    do_reset();
    for (int n = 0; n < 65536; n++) send(1, n & 255);
    idle(2);
    chk("t7_wrap1", int'(sc[1]), 0);
    chk("t7_wrap0", int'(sc[0]), 0);
    chk("sb1_drained", q1.size(), 0);
    chk("sb0_drained", q0.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
